// File: rtl/printer_pkg.sv
// Shared types for the plotter control blocks: homing FSM states and axis ids.
package printer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEEK,
    ST_BACKOFF,
    ST_NEXT,
    ST_DONE,
    ST_ERR
  } home_state_t;

  // Encoding doubles as the bit index into the per-axis {z,y,x} vectors.
  typedef enum logic [1:0] {
    AX_X,
    AX_Y,
    AX_Z
  } axis_t;

endpackage

// File: rtl/limit_debounce.sv
// Limit-switch conditioner: 2-FF synchroniser followed by a stable-count filter.
// The debounced output only follows the synchronised input after it has differed
// from the current debounced value for DEB_CYC consecutive cycles.
module limit_debounce #(
  parameter int DEB_CYC = 40000
) (
  input  logic clk_40,
  input  logic rst,
  input  logic raw,
  output logic deb
);

  localparam int CW = $clog2(DEB_CYC + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  // Synchronise, then count consecutive disagreeing cycles before accepting a change.
  always_ff @(posedge clk_40) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      deb    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == deb) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEB_CYC - 1)) begin
        deb   <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_homing_seq.sv
// Homing sequencer for the three stepper axes: Z, then X, then Y.
// Each axis seeks toward its limit switch, then backs off BACKOFF_STEPS steps.
// Optional feature macro: HOMING_TIMEOUT_EN (seek-step limit of MAX_SEEK_STEPS per axis).
module axis_homing_seq
  import printer_pkg::*;
#(
  parameter int STEP_DIV       = 4000,
  parameter int PULSE_W        = 80,
  parameter int BACKOFF_STEPS  = 200,
  parameter int DEB_CYC        = 40000,
  parameter int MAX_SEEK_STEPS = 20000
) (
  input  logic       clk_40,
  input  logic       rst,
  input  logic       start,
  input  logic       x_calib,
  input  logic       y_calib,
  input  logic       z_calib,
  output logic       step_x,
  output logic       step_y,
  output logic       step_z,
  output logic       dir_x,
  output logic       dir_y,
  output logic       dir_z,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_axis
);

  localparam int TW = $clog2(STEP_DIV);

  // Reject parameter sets that would break the pulse shape or wrap a 16-bit step counter.
  if (PULSE_W < 1 || PULSE_W >= STEP_DIV || BACKOFF_STEPS < 1 || BACKOFF_STEPS > 65535 ||
      MAX_SEEK_STEPS < 1 || MAX_SEEK_STEPS > 65535) begin : g_param_err
    $error("axis_homing_seq: illegal parameter set");
  end

  home_state_t   state_q, state_d;
  axis_t         axis_q, axis_d;
  logic [TW-1:0] t_q;
  logic [15:0]   bo_cnt_q;
  logic [2:0]    lim;      // debounced limits, index = axis_t
  logic [2:0]    dir_q;    // index = axis_t
  logic [1:0]    err_axis_q;
  logic          lim_act, t_zero, t_wrap, entering, step_act;
`ifdef HOMING_TIMEOUT_EN
  logic [15:0]   seek_cnt_q;
`endif

  limit_debounce #(.DEB_CYC(DEB_CYC)) u_deb [2:0] (
    .clk_40 (clk_40),
    .rst    (rst),
    .raw    ({z_calib, y_calib, x_calib}),
    .deb    (lim)
  );

  assign lim_act  = lim[axis_q];
  assign t_zero   = (t_q == '0);
  assign t_wrap   = (t_q == TW'(STEP_DIV - 1));
  assign entering = (state_d != state_q);

  // Next-state and axis sequencing.
  always_comb begin
    state_d = state_q;
    axis_d  = axis_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_SEEK;
          axis_d  = AX_Z;
        end
      end
      ST_SEEK: begin
        // Limit sampled only at period start, so a trip never truncates a pulse.
        if (t_zero && lim_act) state_d = ST_BACKOFF;
`ifdef HOMING_TIMEOUT_EN
        else if (t_wrap && seek_cnt_q == 16'(MAX_SEEK_STEPS - 1)) state_d = ST_ERR;
`endif
      end
      ST_BACKOFF: begin
        // Last backoff pulse ends at this wrap; a still-active switch means it is stuck.
        if (t_wrap && bo_cnt_q == 16'(BACKOFF_STEPS - 1))
          state_d = lim_act ? ST_ERR : ST_NEXT;
      end
      ST_NEXT: begin
        case (axis_q)
          AX_Z:    begin axis_d = AX_X; state_d = ST_SEEK; end
          AX_X:    begin axis_d = AX_Y; state_d = ST_SEEK; end
          default: state_d = ST_DONE;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, step timer, step counters and latched per-axis direction.
  always_ff @(posedge clk_40) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      axis_q     <= AX_Z;
      t_q        <= '0;
      bo_cnt_q   <= '0;
      dir_q      <= '0;
      err_axis_q <= 2'd0;
`ifdef HOMING_TIMEOUT_EN
      seek_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      axis_q  <= axis_d;
      if (entering || t_wrap) t_q <= '0;
      else                    t_q <= t_q + 1'b1;
      if (entering)                              bo_cnt_q <= '0;
      else if (state_q == ST_BACKOFF && t_wrap)  bo_cnt_q <= bo_cnt_q + 1'b1;
`ifdef HOMING_TIMEOUT_EN
      if (entering)                              seek_cnt_q <= '0;
      else if (state_q == ST_SEEK && t_wrap)     seek_cnt_q <= seek_cnt_q + 1'b1;
`endif
      // Direction switches on the same edge as state entry to get full setup time.
      if (state_d == ST_SEEK)         dir_q[axis_d] <= 1'b0;
      else if (state_d == ST_BACKOFF) dir_q[axis_d] <= 1'b1;
      if (state_d == ST_ERR && state_q != ST_ERR) err_axis_q <= axis_q;
    end
  end

  assign step_act = (state_q == ST_SEEK || state_q == ST_BACKOFF) &&
                    (t_q >= TW'(STEP_DIV - PULSE_W));
  assign step_x   = step_act && (axis_q == AX_X);
  assign step_y   = step_act && (axis_q == AX_Y);
  assign step_z   = step_act && (axis_q == AX_Z);
  assign dir_x    = dir_q[AX_X];
  assign dir_y    = dir_q[AX_Y];
  assign dir_z    = dir_q[AX_Z];
  assign busy     = (state_q == ST_SEEK) || (state_q == ST_BACKOFF) || (state_q == ST_NEXT);
  assign done     = (state_q == ST_DONE);
  assign err      = (state_q == ST_ERR);
  assign err_axis = err_axis_q;

endmodule

// File: tb/tb_axis_homing_seq.sv
// Directed bench for axis_homing_seq with small parameters (8-cycle step period).
module tb_axis_homing_seq;

  localparam int AX = 0, AY = 1, AZ = 2;

  logic       clk_40, rst, start;
  logic [2:0] cal;
  logic       x_calib, y_calib, z_calib;
  logic       step_x, step_y, step_z, dir_x, dir_y, dir_z;
  logic       busy, done, err;
  logic [1:0] err_axis;
  logic [2:0] step_v, dir_v;

  int n_chk, n_pass, cyc;
  int rise_cnt [3][2];
  int last_rise_cyc [3];
  int last_bo_cyc [3];
  int hi_run [3];
  int dir_stable [3];
  int pw_bad, dir_bad;
  logic [2:0] step_prev, dir_prev;

  assign x_calib = cal[0];
  assign y_calib = cal[1];
  assign z_calib = cal[2];
  assign step_v  = {step_z, step_y, step_x};
  assign dir_v   = {dir_z, dir_y, dir_x};

  axis_homing_seq #(
    .STEP_DIV(8), .PULSE_W(2), .BACKOFF_STEPS(3), .DEB_CYC(4), .MAX_SEEK_STEPS(10)
  ) dut (
    .clk_40(clk_40), .rst(rst), .start(start),
    .x_calib(x_calib), .y_calib(y_calib), .z_calib(z_calib),
    .step_x(step_x), .step_y(step_y), .step_z(step_z),
    .dir_x(dir_x), .dir_y(dir_y), .dir_z(dir_z),
    .busy(busy), .done(done), .err(err), .err_axis(err_axis)
  );

  initial clk_40 = 1'b0;
  always #5 clk_40 = ~clk_40;

  // Pulse monitor: counts rises per axis/direction, pulse widths and dir setup.
  initial begin
    step_prev = '0;
    dir_prev  = '0;
  end
  always @(negedge clk_40) begin
    cyc++;
    for (int a = 0; a < 3; a++) begin
      if (dir_v[a] != dir_prev[a]) dir_stable[a] = 0;
      else                         dir_stable[a]++;
      if (step_v[a] && !step_prev[a]) begin
        rise_cnt[a][dir_v[a]]++;
        last_rise_cyc[a] = cyc;
        if (dir_v[a]) last_bo_cyc[a] = cyc;
        if (dir_stable[a] < 6) dir_bad++;
        hi_run[a] = 1;
      end else if (step_v[a]) begin
        hi_run[a]++;
      end else if (step_prev[a]) begin
        if (hi_run[a] != 2) pw_bad++;
      end
    end
    step_prev = step_v;
    dir_prev  = dir_v;
  end

  task automatic tick;
    @(negedge clk_40);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rises(input int a, input int d, input int n, input int budget,
                            output bit ok);
    int base, k;
    base = rise_cnt[a][d];
    k = 0;
    while (rise_cnt[a][d] < base + n && k < budget) begin
      tick();
      k++;
    end
    ok = (rise_cnt[a][d] >= base + n);
  endtask

  task automatic wait_low(input int a);
    int k;
    k = 0;
    while (step_v[a] && k < 20) begin
      tick();
      k++;
    end
  endtask

  // Let n seek pulses go by, trip the switch, release it after the first backoff pulse.
  task automatic home_axis(input int a, input int n, output bit ok);
    bit ok1, ok2;
    wait_rises(a, 0, n, 200, ok1);
    wait_low(a);
    cal[a] = 1'b1;
    wait_rises(a, 1, 1, 100, ok2);
    cal[a] = 1'b0;
    ok = ok1 && ok2;
  endtask

  task automatic wait_end;
    int k;
    k = 0;
    while (!(done || err) && k < 400) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; cal = '0;
    tick(); tick();
    n_chk++;
    if ({step_v, dir_v} !== 6'b0) $display("FAIL reset_step_dir: got %b want 000000", {step_v, dir_v});
    else n_pass++;
    n_chk++;
    if ({busy, done, err, err_axis} !== 5'b0) $display("FAIL reset_status: got %b want 00000", {busy, done, err, err_axis});
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_normal;
    int pw0, dr0, n, r0;
    int bo0 [3];
    bit ok, okz, okx, oky;
    pw0 = pw_bad; dr0 = dir_bad;
    for (int a = 0; a < 3; a++) bo0[a] = rise_cnt[a][1];
    pulse_start();
    n_chk++;
    if (busy !== 1'b1) $display("FAIL norm_busy: got %b want 1", busy);
    else n_pass++;
    n = 0;
    while (!step_z && n < 20) begin tick(); n++; end
    n_chk++;
    if (n != 6) $display("FAIL norm_first_rise: got %0d cycles want 6", n);
    else n_pass++;
    r0 = last_rise_cyc[AZ];
    wait_rises(AZ, 0, 1, 20, ok);
    n_chk++;
    if (!ok || last_rise_cyc[AZ] - r0 != 8) $display("FAIL norm_period: got %0d want 8", last_rise_cyc[AZ] - r0);
    else n_pass++;
    home_axis(AZ, 3, okz);
    home_axis(AX, 2, okx);
    home_axis(AY, 7, oky);
    n_chk++;
    if (!(okz && okx && oky)) $display("FAIL norm_progress: got z%0b x%0b y%0b want 111", okz, okx, oky);
    else n_pass++;
    wait_end();
    n_chk++;
    if ({done, busy, err} !== 3'b100) $display("FAIL norm_status: got done/busy/err %b want 100", {done, busy, err});
    else n_pass++;
    for (int a = 0; a < 3; a++) begin
      n_chk++;
      if (rise_cnt[a][1] - bo0[a] != 3) $display("FAIL norm_backoff_ax%0d: got %0d want 3", a, rise_cnt[a][1] - bo0[a]);
      else n_pass++;
    end
    n_chk++;
    if (!(last_bo_cyc[AZ] < last_bo_cyc[AX] && last_bo_cyc[AX] < last_bo_cyc[AY]))
      $display("FAIL norm_order: got z%0d x%0d y%0d want ascending", last_bo_cyc[AZ], last_bo_cyc[AX], last_bo_cyc[AY]);
    else n_pass++;
    n_chk++;
    if (pw_bad != pw0) $display("FAIL norm_pulse_width: got %0d bad pulses want 0", pw_bad - pw0);
    else n_pass++;
    n_chk++;
    if (dir_bad != dr0) $display("FAIL norm_dir_setup: got %0d short setups want 0", dir_bad - dr0);
    else n_pass++;
  endtask

  task automatic test_stuck;
    int xs0, xb0;
    bit ok;
    cal[AX] = 1'b1;
    xs0 = rise_cnt[AX][0]; xb0 = rise_cnt[AX][1];
    pulse_start();
    n_chk++;
    if ({busy, done} !== 2'b10) $display("FAIL stuck_start: got busy/done %b want 10", {busy, done});
    else n_pass++;
    home_axis(AZ, 1, ok);
    wait_end();
    n_chk++;
    if (!ok || {err, busy, done} !== 3'b100) $display("FAIL stuck_status: got err/busy/done %b want 100", {err, busy, done});
    else n_pass++;
    n_chk++;
    if (err_axis !== 2'd0) $display("FAIL stuck_err_axis: got %0d want 0", err_axis);
    else n_pass++;
    n_chk++;
    if (rise_cnt[AX][0] != xs0 || rise_cnt[AX][1] - xb0 != 3)
      $display("FAIL stuck_pulses: got seek %0d backoff %0d want 0 3", rise_cnt[AX][0] - xs0, rise_cnt[AX][1] - xb0);
    else n_pass++;
    cal[AX] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_bounce;
    int yb0;
    bit ok, ok1, ok2;
    pulse_start();
    n_chk++;
    if ({busy, err} !== 2'b10) $display("FAIL bounce_start: got busy/err %b want 10", {busy, err});
    else n_pass++;
    home_axis(AZ, 1, ok);
    home_axis(AX, 1, ok1);
    wait_rises(AY, 0, 1, 200, ok2);
    yb0 = rise_cnt[AY][1];
    repeat (3) begin
      cal[AY] = 1'b1; repeat (3) tick();
      cal[AY] = 1'b0; repeat (3) tick();
    end
    wait_rises(AY, 0, 1, 40, ok);
    n_chk++;
    if (!(ok && ok1 && ok2)) $display("FAIL bounce_seek_continues: got %0b want 1", ok && ok1 && ok2);
    else n_pass++;
    n_chk++;
    if (rise_cnt[AY][1] != yb0 || dir_y !== 1'b0 || busy !== 1'b1)
      $display("FAIL bounce_no_backoff: got bo %0d dir %b busy %b want 0 0 1", rise_cnt[AY][1] - yb0, dir_y, busy);
    else n_pass++;
    home_axis(AY, 0, ok);
    wait_end();
    n_chk++;
    if (!ok || done !== 1'b1) $display("FAIL bounce_done: got %b want 1", done);
    else n_pass++;
  endtask

  task automatic test_control;
    int r0, zs0;
    bit ok;
    pulse_start();
    wait_rises(AZ, 0, 1, 20, ok);
    r0 = last_rise_cyc[AZ];
    tick();
    pulse_start();
    n_chk++;
    if ({busy, done} !== 2'b10) $display("FAIL ctrl_start_ignored: got busy/done %b want 10", {busy, done});
    else n_pass++;
    wait_rises(AZ, 0, 1, 20, ok);
    n_chk++;
    if (!ok || last_rise_cyc[AZ] - r0 != 8) $display("FAIL ctrl_period_kept: got %0d want 8", last_rise_cyc[AZ] - r0);
    else n_pass++;
    wait_low(AZ);
    cal[AZ] = 1'b1;
    wait_rises(AZ, 1, 1, 40, ok);
    rst = 1'b1;
    tick();
    n_chk++;
    if (!ok || {step_v, dir_v, busy, done, err, err_axis} !== 11'b0)
      $display("FAIL ctrl_reset_outputs: got %b want 0", {step_v, dir_v, busy, done, err, err_axis});
    else n_pass++;
    rst = 1'b0;
    cal = '0;
    zs0 = rise_cnt[AZ][0] + rise_cnt[AZ][1];
    repeat (20) tick();
    n_chk++;
    if (rise_cnt[AZ][0] + rise_cnt[AZ][1] != zs0 || busy !== 1'b0)
      $display("FAIL ctrl_idle: got rises %0d busy %b want 0 0", rise_cnt[AZ][0] + rise_cnt[AZ][1] - zs0, busy);
    else n_pass++;
  endtask

  task automatic test_timeout;
    int zs0;
    bit ok;
    zs0 = rise_cnt[AZ][0];
    pulse_start();
`ifdef HOMING_TIMEOUT_EN
    wait_rises(AZ, 0, 10, 200, ok);
    wait_low(AZ);
    n_chk++;
    if (!ok || {err, busy} !== 2'b10) $display("FAIL timeout_err: got err/busy %b want 10", {err, busy});
    else n_pass++;
    n_chk++;
    if (err_axis !== 2'd2) $display("FAIL timeout_err_axis: got %0d want 2", err_axis);
    else n_pass++;
    repeat (20) tick();
    n_chk++;
    if (rise_cnt[AZ][0] - zs0 != 10) $display("FAIL timeout_pulses: got %0d want 10", rise_cnt[AZ][0] - zs0);
    else n_pass++;
`else
    wait_rises(AZ, 0, 12, 200, ok);
    n_chk++;
    if (!ok || {err, busy} !== 2'b01) $display("FAIL unbounded_seek: got ok %0b err/busy %b want 1 01", ok, {err, busy});
    else n_pass++;
    n_chk++;
    if (rise_cnt[AZ][1] != 0 && dir_z !== 1'b0) $display("FAIL unbounded_dir: got %b want 0", dir_z);
    else n_pass++;
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    test_reset();
    test_normal();
    test_stuck();
    test_bounce();
    test_control();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
